pipeline_hazard_control: RTL and testbench
==========================================

Name: pipeline_hazard_control

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the Write/clear controls of the PC, the IF/ID register and the ID/EX register.
- Stalls on load-use hazards and holds EX for multi-cycle ALU functions (mult/div) using an internal counter.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.

Parameters:
- REG_ADDR_W, 5, register-index width.
- FUNCT_W, 6, width of the ALU function code carried in ID/EX.
- MULTI_LATENCY, 4, total EX-stage cycles for a multi-cycle function; legal range is 2..15.

Ports:
- clock  in  1  pipeline clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ID_Rs  in  REG_ADDR_W  source register rs of the instruction in ID.
- ID_Rt  in  REG_ADDR_W  source register rt of the instruction in ID.
- ID_Uses_Rt  in  1  ID instruction reads rt.
- EX_Rt  in  REG_ADDR_W  destination register of the instruction in EX (load target).
- EX_MemRead  in  1  instruction in EX is a load.
- EX_Valid  in  1  EX holds a real instruction, not a bubble.
- EX_Function_ULA  in  FUNCT_W  ALU function of the instruction in EX.
- Branch_Taken  in  1  branch in EX resolved taken this cycle.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID Write.
- IF_ID_Clear  out  1  IF/ID clear.
- ID_EX_Write  out  1  ID/EX Write.
- ID_EX_Clear  out  1  ID/EX clear; inserts a bubble.
- Busy  out  1  a multi-cycle function occupies EX.
- Stall_Cycles  out  16  stall statistics (see Optional Feature).
- Flush_Count  out  16  flush statistics (see Optional Feature).

Behaviour:
- State and counter:
  - States: RUN and MULTI.
  - 4-bit down-counter cnt.
  - Reset (asynchronous, reset_n=0): state=RUN, cnt=0.
- Outputs while reset_n=0:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0.
  - IF_ID_Clear=1, ID_EX_Clear=1, Busy=0.
  - Stats=0.
- Outputs are combinational from state, cnt and the current inputs. Pipeline registers sample them on the same edge (zero latency).
- Default (no event): all Write=1, all Clear=0, Busy=0.
- Event priority, highest first:
  - (1) MULTI hold.
  - (2) Branch flush.
  - (3) Multi-cycle detect.
  - (4) Load-use.
- MULTI hold, when state=MULTI and cnt!=0:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, ID_EX_Clear=0, Busy=1.
  - Branch_Taken and load-use are ignored.
  - Next cnt=cnt-1.
- MULTI release, when state=MULTI and cnt=0:
  - Outputs take default/branch/load-use values; multi detect is suppressed.
  - Next state=RUN.
- Branch flush (Branch_Taken=1, not holding):
  - PC_Write=1, IF_ID_Clear=1, ID_EX_Clear=1.
  - Write outputs stay 1; clear dominates inside the registers.
- Multi detect, when state=RUN, EX_Valid=1, EX_Function_ULA is in {MULT, MULTU, DIV, DIVU} and Branch_Taken=0:
  - Hold outputs as in MULTI, Busy=1.
  - Next state=MULTI, cnt=MULTI_LATENCY-2.
  - Stalled cycles total MULTI_LATENCY-1; EX occupancy is MULTI_LATENCY cycles.
- MULTI_LATENCY=2: MULTI is entered with cnt=0, so release happens on the next cycle.
- Load-use trigger: EX_Valid and EX_MemRead and EX_Rt!=0, and either EX_Rt==ID_Rs, or ID_Uses_Rt and EX_Rt==ID_Rt.
- Load-use response: PC_Write=0, IF_ID_Write=0, ID_EX_Write=1, ID_EX_Clear=1. Lasts exactly one cycle, because the load advances to MEM.
- Register 0 never triggers a hazard.
- Reset mid-MULTI: returns to RUN immediately; the held op is discarded by the register clears.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - Stall_Cycles increments on every cycle with PC_Write=0 while reset_n=1.
  - Flush_Count increments on every accepted Branch_Taken flush.
  - Both counters saturate at 16'hFFFF.
  - Both reset to 0 asynchronously.
- Undefined: Stall_Cycles and Flush_Count are tied to 16'h0000 and no counter logic is synthesized.

Decomposition:
- Shared package hazard_pkg holds:
  - FUNCT_MULT=6'b011000, FUNCT_MULTU=6'b011001, FUNCT_DIV=6'b011010, FUNCT_DIVU=6'b011011.
  - State encoding: ST_RUN=1'b0, ST_MULTI=1'b1.
  - Statistics width constant STAT_W=16.
- One sub-module: hazard_stat_counter, a saturating 16-bit counter with async active-low reset and an increment enable. It is instantiated twice, only under HAZARD_STATS_EN.

Test Plan:
- Reset: hold reset_n=0 mid-cycle, then release.
  - Expect Clears=1 and Writes=0 while reset is low.
  - Expect default outputs on the first cycle after release.
- Load-use: EX_MemRead=1, EX_Valid=1, EX_Rt=5, ID_Rs=5.
  - Expect one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Clear=1.
  - Repeat with EX_Rt=0: expect no stall.
- Multi-cycle: EX_Function_ULA=6'b011010 with MULTI_LATENCY=4.
  - Expect Busy=1 and all Writes=0 for 3 consecutive cycles, then release; Writes=1 on the 4th cycle.
- Priority:
  - Branch_Taken=1 with a load-use condition present: expect a flush (both Clears=1, PC_Write=1), not a stall.
  - Branch_Taken=1 during a MULTI hold: expect it ignored.
- Async reset asserted during MULTI with cnt=1: expect an immediate return to RUN and Busy=0.
- HAZARD_STATS_EN: one load-use stall plus a 3-cycle mult stall plus 2 flushes.
  - Expect Stall_Cycles=4 and Flush_Count=2.
  - Without the macro, both ports read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: multi-cycle ALU
// function codes, FSM state encoding and the statistics counter width.
package hazard_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/hazard_stat_counter.sv
// Saturating event counter with asynchronous active-low reset; used for the
// optional hazard statistics.
module hazard_stat_counter
  import hazard_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_control.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, multi-cycle
// EX holds and branch flushes. Optional statistics under HAZARD_STATS_EN.
module pipeline_hazard_control
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W    = 5,
  parameter int FUNCT_W       = 6,
  parameter int MULTI_LATENCY = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_Uses_Rt,
  input  logic [REG_ADDR_W-1:0] EX_Rt,
  input  logic                  EX_MemRead,
  input  logic                  EX_Valid,
  input  logic [FUNCT_W-1:0]    EX_Function_ULA,
  input  logic                  Branch_Taken,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  IF_ID_Clear,
  output logic                  ID_EX_Write,
  output logic                  ID_EX_Clear,
  output logic                  Busy,
  output logic [STAT_W-1:0]     Stall_Cycles,
  output logic [STAT_W-1:0]     Flush_Count
);

  // The detect cycle itself is one stalled cycle, so the counter covers the rest.
  localparam logic [3:0] CNT_LOAD = 4'(MULTI_LATENCY - 2);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;

  logic w_hold;
  logic w_is_multi_fn;
  logic w_multi_detect;
  logic w_load_use;

  assign w_hold = (r_state == ST_MULTI) && (r_cnt != 4'd0);

  assign w_is_multi_fn = (EX_Function_ULA == FUNCT_W'(FUNCT_MULT))  ||
                         (EX_Function_ULA == FUNCT_W'(FUNCT_MULTU)) ||
                         (EX_Function_ULA == FUNCT_W'(FUNCT_DIV))   ||
                         (EX_Function_ULA == FUNCT_W'(FUNCT_DIVU));

  assign w_multi_detect = (r_state == ST_RUN) && EX_Valid && w_is_multi_fn && !Branch_Taken;

  assign w_load_use = EX_Valid && EX_MemRead && (EX_Rt != '0) &&
                      ((EX_Rt == ID_Rs) || (ID_Uses_Rt && (EX_Rt == ID_Rt)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_multi_detect) begin
          w_state_next = ST_MULTI;
          w_cnt_next   = CNT_LOAD;
        end
      end
      ST_MULTI: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      default: begin
        w_state_next = ST_RUN;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  // Reset is folded in so the pipeline registers are cleared while reset_n is low.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Clear = 1'b0;
    ID_EX_Write = 1'b1;
    ID_EX_Clear = 1'b0;
    Busy        = 1'b0;
    if (!reset_n) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      IF_ID_Clear = 1'b1;
      ID_EX_Clear = 1'b1;
    end else if (w_hold || w_multi_detect) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      Busy        = 1'b1;
    end else if (Branch_Taken) begin
      IF_ID_Clear = 1'b1;
      ID_EX_Clear = 1'b1;
    end else if (w_load_use) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Clear = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = reset_n && !PC_Write;
  assign w_flush_inc = reset_n && Branch_Taken && !w_hold;

  hazard_stat_counter #(.W(STAT_W)) u_stall_cnt (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_inc   (w_stall_inc),
    .o_count (Stall_Cycles)
  );

  hazard_stat_counter #(.W(STAT_W)) u_flush_cnt (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_inc   (w_flush_inc),
    .o_count (Flush_Count)
  );
`else
  assign Stall_Cycles = '0;
  assign Flush_Count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_control.sv
// Scoreboard bench for pipeline_hazard_control: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_control;

  logic        clock;
  logic        reset_n;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_Uses_Rt;
  logic [4:0]  EX_Rt;
  logic        EX_MemRead;
  logic        EX_Valid;
  logic [5:0]  EX_Function_ULA;
  logic        Branch_Taken;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Clear;
  logic        ID_EX_Write;
  logic        ID_EX_Clear;
  logic        Busy;
  logic [15:0] Stall_Cycles;
  logic [15:0] Flush_Count;

  pipeline_hazard_control #(
    .REG_ADDR_W   (5),
    .FUNCT_W      (6),
    .MULTI_LATENCY(4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_Uses_Rt     (ID_Uses_Rt),
    .EX_Rt          (EX_Rt),
    .EX_MemRead     (EX_MemRead),
    .EX_Valid       (EX_Valid),
    .EX_Function_ULA(EX_Function_ULA),
    .Branch_Taken   (Branch_Taken),
    .PC_Write       (PC_Write),
    .IF_ID_Write    (IF_ID_Write),
    .IF_ID_Clear    (IF_ID_Clear),
    .ID_EX_Write    (ID_EX_Write),
    .ID_EX_Clear    (ID_EX_Clear),
    .Busy           (Busy),
    .Stall_Cycles   (Stall_Cycles),
    .Flush_Count    (Flush_Count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef HAZARD_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  // Expected control word: {PC_Write, IF_ID_Write, IF_ID_Clear, ID_EX_Write, ID_EX_Clear, Busy}
  localparam logic [5:0] E_DEF   = 6'b110100;
  localparam logic [5:0] E_RST   = 6'b001010;
  localparam logic [5:0] E_HOLD  = 6'b000001;
  localparam logic [5:0] E_FLUSH = 6'b111110;
  localparam logic [5:0] E_LU    = 6'b000110;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_MULT = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef struct {
    string      nm;
    logic [5:0] ctl;
    logic       chk_stats;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  exp_t        mon_e;
  logic [5:0]  mon_got;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_got = {PC_Write, IF_ID_Write, IF_ID_Clear, ID_EX_Write, ID_EX_Clear, Busy};
      checks++;
      if (mon_got !== mon_e.ctl) begin
        failures++;
        $display("FAIL %s: ctl got=%b exp=%b", mon_e.nm, mon_got, mon_e.ctl);
      end else begin
        $display("ok   %s: ctl=%b", mon_e.nm, mon_got);
      end
      if (mon_e.chk_stats) begin
        checks++;
        if (Stall_Cycles !== 16'(mon_e.stall) || Flush_Count !== 16'(mon_e.flush)) begin
          failures++;
          $display("FAIL %s_stats: got stall=%0d flush=%0d exp stall=%0d flush=%0d",
                   mon_e.nm, Stall_Cycles, Flush_Count, mon_e.stall, mon_e.flush);
        end else begin
          $display("ok   %s_stats: stall=%0d flush=%0d", mon_e.nm, Stall_Cycles, Flush_Count);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rst_n,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] ex_rt, input logic mr, input logic v,
                      input logic [5:0] fn, input logic br,
                      input logic [5:0] ctl, input logic cs, input int es, input int ef);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n         = rst_n;
    ID_Rs           = rs;
    ID_Rt           = rt;
    ID_Uses_Rt      = urt;
    EX_Rt           = ex_rt;
    EX_MemRead      = mr;
    EX_Valid        = v;
    EX_Function_ULA = fn;
    Branch_Taken    = br;
    e.nm        = nm;
    e.ctl       = ctl;
    e.chk_stats = cs;
    e.stall     = es;
    e.flush     = ef;
    sb.push_back(e);
  endtask

  initial begin
    reset_n         = 1'b0;
    ID_Rs           = '0;
    ID_Rt           = '0;
    ID_Uses_Rt      = 1'b0;
    EX_Rt           = '0;
    EX_MemRead      = 1'b0;
    EX_Valid        = 1'b0;
    EX_Function_ULA = '0;
    Branch_Taken    = 1'b0;

    //    name            rst rs  rt  urt exrt mr v  fn      br  ctl     cs es           ef
    step("reset_low",     0, 5'd5, 5'd0, 0, 5'd5, 1, 1, F_ADD, 1, E_RST,   1, 0,           0);
    step("reset_release", 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, F_ADD, 0, E_DEF,   0, 0,           0);
    step("idle",          1, 5'd1, 5'd2, 1, 5'd3, 0, 1, F_ADD, 0, E_DEF,   0, 0,           0);
    step("load_use_rs",   1, 5'd5, 5'd0, 0, 5'd5, 1, 1, F_ADD, 0, E_LU,    0, 0,           0);
    step("load_advanced", 1, 5'd5, 5'd0, 0, 5'd9, 0, 1, F_ADD, 0, E_DEF,   0, 0,           0);
    step("load_use_r0",   1, 5'd0, 5'd0, 1, 5'd0, 1, 1, F_ADD, 0, E_DEF,   0, 0,           0);
    step("br_over_lu",    1, 5'd5, 5'd0, 0, 5'd5, 1, 1, F_ADD, 1, E_FLUSH, 0, 0,           0);
    step("div_detect",    1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_DIV, 0, E_HOLD,  0, 0,           0);
    step("div_hold_br",   1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_DIV, 1, E_HOLD,  0, 0,           0);
    step("div_hold_lu",   1, 5'd6, 5'd0, 0, 5'd6, 1, 1, F_DIV, 0, E_HOLD,  0, 0,           0);
    step("div_release",   1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_DIV, 0, E_DEF,   0, 0,           0);
    step("branch_flush",  1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_ADD, 1, E_FLUSH, 0, 0,           0);
    step("stats_check",   1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_ADD, 0, E_DEF,   1, 4*STATS_ON,  2*STATS_ON);
    step("load_use_rt",   1, 5'd3, 5'd7, 1, 5'd7, 1, 1, F_ADD, 0, E_LU,    0, 0,           0);
    step("rt_not_used",   1, 5'd3, 5'd7, 0, 5'd7, 1, 1, F_ADD, 0, E_DEF,   0, 0,           0);
    step("lu_ex_bubble",  1, 5'd7, 5'd7, 1, 5'd7, 1, 0, F_ADD, 0, E_DEF,   0, 0,           0);
    step("mult_bubble",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, F_MULT, 0, E_DEF,  0, 0,           0);
    step("multu_br",      1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_MULTU, 1, E_FLUSH, 0, 0,         0);
    step("multu_detect",  1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_MULTU, 0, E_HOLD, 0, 0,          0);
    step("multu_hold",    1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_MULTU, 0, E_HOLD, 0, 0,          0);
    step("reset_in_multi",0, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_MULTU, 0, E_RST,  1, 0,          0);
    step("after_reset",   1, 5'd0, 5'd0, 0, 5'd0, 0, 0, F_ADD, 0, E_DEF,   0, 0,           0);
    step("final_idle",    1, 5'd0, 5'd0, 0, 5'd0, 0, 1, F_ADD, 0, E_DEF,   1, 0,           0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, exp 0", sb.size());
    end
    @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
